// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: packet layout and index widths.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wb_pkg;

    localparam int DEPTH     = 64;
    localparam int PHYS_REGS = 128;
    localparam int XLEN      = 32;

    localparam int ROB_IDX_W = $clog2(DEPTH);
    localparam int PRF_IDX_W = $clog2(PHYS_REGS);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PRF_IDX_W-1:0] dest_prf;
        logic                 rd_wen;
        logic [XLEN-1:0]      value;
        logic                 exception;
        logic                 mispred;
    } wb_packet_t;

endpackage

// File: rtl/rr_multi_picker.sv
// Rotating-priority multi-grant picker: grants up to WB_WIDTH requesters starting at i_rr_ptr.
// Latency: purely combinational.
// Backpressure: none; requesters not granted simply stay ungranted this cycle.
// Ports: i_req/i_rr_ptr in; o_grant (one-hot per FU), o_slot_vld/o_slot_idx (per writeback slot),
//        o_last_idx (last FU granted in scan order), o_any (at least one grant).
module rr_multi_picker #(
    parameter  int NUM_FU   = 6,
    parameter  int WB_WIDTH = 4,
    localparam int PTR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic [NUM_FU-1:0]   i_req,
    input  logic [PTR_W-1:0]    i_rr_ptr,
    output logic [NUM_FU-1:0]   o_grant,
    output logic [WB_WIDTH-1:0] o_slot_vld,
    output logic [PTR_W-1:0]    o_slot_idx [WB_WIDTH],
    output logic [PTR_W-1:0]    o_last_idx,
    output logic                o_any
);

    always_comb begin
        int   idx;
        int   cnt;
        logic req_at;
        o_grant    = '0;
        o_slot_vld = '0;
        for (int s = 0; s < WB_WIDTH; s++) o_slot_idx[s] = '0;
        o_last_idx = i_rr_ptr;
        idx        = 0;
        cnt        = 0;
        req_at     = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            // Explicit wrap so NUM_FU need not be a power of two.
            idx = int'(i_rr_ptr) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            // Constant-index selects keep the unrolled logic a plain mux.
            req_at = 1'b0;
            for (int f = 0; f < NUM_FU; f++) if (f == idx) req_at = i_req[f];
            if (req_at && (cnt < WB_WIDTH)) begin
                for (int f = 0; f < NUM_FU; f++) if (f == idx) o_grant[f] = 1'b1;
                for (int s = 0; s < WB_WIDTH; s++) begin
                    if (s == cnt) begin
                        o_slot_vld[s] = 1'b1;
                        o_slot_idx[s] = PTR_W'(idx);
                    end
                end
                o_last_idx = PTR_W'(idx);
                cnt        = cnt + 1;
            end
        end
        o_any = |o_grant;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-FU hold registers, round-robin grant of up to WB_WIDTH results into ROB/CDB slots.
// Latency: 2 cycles FU handshake -> wb_valid_o (hold register, then registered slot outputs).
// Backpressure: fu_ready_o low only for a loaded hold register that lost arbitration; flush drops everything.
// Ports: clock, reset_n (sync, active-low), flush_i; fu_valid_i/fu_ready_o/fu_pkt_i per FU;
//        wb_valid_o/wb_pkt_o per writeback slot. Define WB_ARB_STATS_EN to add stat_grant_cnt_o
//        and stat_conflict_cnt_o.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter  int NUM_FU   = 6,
    parameter  int WB_WIDTH = 4,
    localparam int PTR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush_i,
    input  logic [NUM_FU-1:0]   fu_valid_i,
    output logic [NUM_FU-1:0]   fu_ready_o,
    input  wb_packet_t          fu_pkt_i [NUM_FU],
    output logic [WB_WIDTH-1:0] wb_valid_o,
    output wb_packet_t          wb_pkt_o [WB_WIDTH]
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]         stat_grant_cnt_o,
    output logic [31:0]         stat_conflict_cnt_o
`endif
);

    logic [NUM_FU-1:0]   r_hold_valid;
    wb_packet_t          r_hold_pkt [NUM_FU];
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [WB_WIDTH-1:0] r_wb_valid;
    wb_packet_t          r_wb_pkt [WB_WIDTH];

    logic [NUM_FU-1:0]   w_grant;
    logic [WB_WIDTH-1:0] w_slot_vld;
    logic [PTR_W-1:0]    w_slot_idx [WB_WIDTH];
    logic [PTR_W-1:0]    w_last_idx;
    logic                w_any;
    logic [NUM_FU-1:0]   w_fu_ready;
    logic [NUM_FU-1:0]   w_load;
    logic [PTR_W-1:0]    w_rr_next;

    rr_multi_picker #(
        .NUM_FU   (NUM_FU),
        .WB_WIDTH (WB_WIDTH)
    ) u_picker (
        .i_req      (r_hold_valid),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant    (w_grant),
        .o_slot_vld (w_slot_vld),
        .o_slot_idx (w_slot_idx),
        .o_last_idx (w_last_idx),
        .o_any      (w_any)
    );

    // A granted hold empties at this edge, so it can take a new result in the same cycle.
    assign w_fu_ready = ~r_hold_valid | w_grant | {NUM_FU{flush_i}};
    assign w_load     = fu_valid_i & w_fu_ready & {NUM_FU{~flush_i}};
    assign w_rr_next  = (w_last_idx == PTR_W'(NUM_FU - 1)) ? '0 : w_last_idx + 1'b1;

    assign fu_ready_o = w_fu_ready;
    assign wb_valid_o = r_wb_valid;
    assign wb_pkt_o   = r_wb_pkt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_hold_valid <= '0;
            r_rr_ptr     <= '0;
            r_wb_valid   <= '0;
            for (int s = 0; s < WB_WIDTH; s++) r_wb_pkt[s] <= '0;
        end else if (flush_i) begin
            // Pointer is kept across a flush; only in-flight results are discarded.
            r_hold_valid <= '0;
            r_wb_valid   <= '0;
            for (int s = 0; s < WB_WIDTH; s++) r_wb_pkt[s] <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_load[i])       r_hold_valid[i] <= 1'b1;
                else if (w_grant[i]) r_hold_valid[i] <= 1'b0;
            end
            r_wb_valid <= w_slot_vld;
            for (int s = 0; s < WB_WIDTH; s++)
                r_wb_pkt[s] <= w_slot_vld[s] ? r_hold_pkt[w_slot_idx[s]] : '0;
            if (w_any) r_rr_ptr <= w_rr_next;
        end
    end

    // Payload needs no reset: it is only observed while its valid bit is set.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++)
            if (w_load[i]) r_hold_pkt[i] <= fu_pkt_i[i];
    end

`ifdef WB_ARB_STATS_EN
    logic [31:0] r_stat_grant;
    logic [31:0] r_stat_conflict;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_stat_grant    <= '0;
            r_stat_conflict <= '0;
        end else if (!flush_i) begin
            r_stat_grant <= r_stat_grant + 32'($countones(w_grant));
            if ($countones(r_hold_valid) > WB_WIDTH) r_stat_conflict <= r_stat_conflict + 32'd1;
        end
    end

    assign stat_grant_cnt_o    = r_stat_grant;
    assign stat_conflict_cnt_o = r_stat_conflict;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default 4-slot instance plus a 1-slot instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       flush_i;
    logic [5:0] fu_valid;
    logic [5:0] fu_ready;
    wb_packet_t fu_pkt [6];
    logic [3:0] wb_valid;
    wb_packet_t wb_pkt [4];

    logic       flush1;
    logic [5:0] fu_valid1;
    logic [5:0] fu_ready1;
    wb_packet_t fu_pkt1 [6];
    logic [0:0] wb_valid1;
    wb_packet_t wb_pkt1 [1];

`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_grant, stat_conflict, stat_grant1, stat_conflict1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    wb_arbiter #(.NUM_FU(6), .WB_WIDTH(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush_i    (flush_i),
        .fu_valid_i (fu_valid),
        .fu_ready_o (fu_ready),
        .fu_pkt_i   (fu_pkt),
        .wb_valid_o (wb_valid),
        .wb_pkt_o   (wb_pkt)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_grant_cnt_o    (stat_grant),
        .stat_conflict_cnt_o (stat_conflict)
`endif
    );

    wb_arbiter #(.NUM_FU(6), .WB_WIDTH(1)) dut1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush_i    (flush1),
        .fu_valid_i (fu_valid1),
        .fu_ready_o (fu_ready1),
        .fu_pkt_i   (fu_pkt1),
        .wb_valid_o (wb_valid1),
        .wb_pkt_o   (wb_pkt1)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_grant_cnt_o    (stat_grant1),
        .stat_conflict_cnt_o (stat_conflict1)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic wb_packet_t mkpkt(input int rob, input int prf, input logic [31:0] val);
        wb_packet_t p;
        p           = '0;
        p.rob_idx   = ROB_IDX_W'(rob);
        p.dest_prf  = PRF_IDX_W'(prf);
        p.rd_wen    = 1'b1;
        p.value     = val;
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush_i   = 1'b0;
        fu_valid  = '0;
        flush1    = 1'b0;
        fu_valid1 = '0;
        for (int i = 0; i < 6; i++) begin
            fu_pkt[i]  = '0;
            fu_pkt1[i] = '0;
        end

        // Reset
        tick();
        tick();
        check_eq("rst_wb_valid", 64'(wb_valid), 64'h0);
        check_eq("rst_fu_ready", 64'(fu_ready), 64'h3f);
        for (int s = 0; s < 4; s++) check_eq("rst_wb_pkt", 64'(wb_pkt[s]), 64'h0);
        reset_n = 1'b1;

        // Single result from FU2: visible two edges after presentation
        fu_pkt[2] = mkpkt(5, 40, 32'hDEAD);
        fu_valid  = 6'b000100;
        tick();
        fu_valid = '0;
        check_eq("single_not_early", 64'(wb_valid), 64'h0);
        tick();
        check_eq("single_wb_valid", 64'(wb_valid), 64'h1);
        check_eq("single_rob", 64'(wb_pkt[0].rob_idx), 64'd5);
        check_eq("single_prf", 64'(wb_pkt[0].dest_prf), 64'd40);
        check_eq("single_value", 64'(wb_pkt[0].value), 64'hDEAD);
        check_eq("single_slot1_zero", 64'(wb_pkt[1]), 64'h0);
        tick();
        check_eq("single_pulse", 64'(wb_valid), 64'h0);

        // Sustained one-per-cycle from FU0
        fu_valid  = 6'b000001;
        fu_pkt[0] = mkpkt(20, 1, 32'd20);
        tick();
        fu_pkt[0] = mkpkt(21, 1, 32'd21);
        tick();
        check_eq("thru_rob20", 64'(wb_pkt[0].rob_idx), 64'd20);
        fu_pkt[0] = mkpkt(22, 1, 32'd22);
        tick();
        fu_valid = '0;
        check_eq("thru_rob21", 64'(wb_pkt[0].rob_idx), 64'd21);
        tick();
        check_eq("thru_rob22", 64'(wb_pkt[0].rob_idx), 64'd22);
        check_eq("thru_valid", 64'(wb_valid), 64'h1);
        tick();

        // Contention: reset to bring the pointer back to 0, then all six FUs at once
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) fu_pkt[i] = mkpkt(10 + i, 50 + i, 32'(100 + i));
        fu_valid = 6'h3f;
        tick();
        fu_valid = '0;
        check_eq("cont_ready_losers", 64'(fu_ready), 64'h0f);
        tick();
        check_eq("cont_wb1_valid", 64'(wb_valid), 64'hf);
        check_eq("cont_wb1_s0", 64'(wb_pkt[0].rob_idx), 64'd10);
        check_eq("cont_wb1_s1", 64'(wb_pkt[1].rob_idx), 64'd11);
        check_eq("cont_wb1_s2", 64'(wb_pkt[2].rob_idx), 64'd12);
        check_eq("cont_wb1_s3", 64'(wb_pkt[3].rob_idx), 64'd13);
        check_eq("cont_ready_after", 64'(fu_ready), 64'h3f);
        tick();
        check_eq("cont_wb2_valid", 64'(wb_valid), 64'h3);
        check_eq("cont_wb2_s0", 64'(wb_pkt[0].rob_idx), 64'd14);
        check_eq("cont_wb2_s1", 64'(wb_pkt[1].rob_idx), 64'd15);
        check_eq("cont_wb2_s1_val", 64'(wb_pkt[1].value), 64'd105);
        check_eq("cont_wb2_s2_zero", 64'(wb_pkt[2]), 64'h0);
`ifdef WB_ARB_STATS_EN
        check_eq("stat_grant", 64'(stat_grant), 64'd6);
        check_eq("stat_conflict", 64'(stat_conflict), 64'd1);
`endif

        // Pointer wrapped to 0: FU0 must precede FU5
        fu_pkt[0] = mkpkt(40, 2, 32'd40);
        fu_pkt[5] = mkpkt(45, 3, 32'd45);
        fu_valid  = 6'b100001;
        tick();
        fu_valid = '0;
        tick();
        check_eq("ptr_wrap_valid", 64'(wb_valid), 64'h3);
        check_eq("ptr_wrap_s0", 64'(wb_pkt[0].rob_idx), 64'd40);
        check_eq("ptr_wrap_s1", 64'(wb_pkt[1].rob_idx), 64'd45);
        tick();

        // Flush with FU1/FU3 holding and a new FU1 transfer in the flush cycle
        fu_pkt[1] = mkpkt(1, 4, 32'd1);
        fu_pkt[3] = mkpkt(3, 5, 32'd3);
        fu_valid  = 6'b001010;
        tick();
        flush_i   = 1'b1;
        fu_pkt[1] = mkpkt(33, 6, 32'd33);
        fu_valid  = 6'b000010;
        check_eq("flush_ready", 64'(fu_ready), 64'h3f);
        tick();
        flush_i  = 1'b0;
        fu_valid = '0;
        check_eq("flush_wb_off", 64'(wb_valid), 64'h0);
        check_eq("flush_pkt_zero", 64'(wb_pkt[0]), 64'h0);
        check_eq("flush_ready_after", 64'(fu_ready), 64'h3f);
        tick();
        check_eq("flush_no_late1", 64'(wb_valid), 64'h0);
        tick();
        check_eq("flush_no_late2", 64'(wb_valid), 64'h0);

        // Single-slot instance: park pointer at 5 via FU4, then FU5/FU0 alternate
        fu_pkt1[4] = mkpkt(4, 7, 32'd4);
        fu_valid1  = 6'b010000;
        tick();
        fu_valid1 = '0;
        tick();
        check_eq("rot_pre_valid", 64'(wb_valid1), 64'h1);
        check_eq("rot_pre_rob", 64'(wb_pkt1[0].rob_idx), 64'd4);
        fu_pkt1[5] = mkpkt(50, 8, 32'd50);
        fu_pkt1[0] = mkpkt(60, 9, 32'd60);
        fu_valid1  = 6'b100001;
        tick();
        check_eq("rot_loser_ready", 64'(fu_ready1), 64'h3e);
        tick();
        check_eq("rot_g1", 64'(wb_pkt1[0].rob_idx), 64'd50);
        tick();
        check_eq("rot_g2", 64'(wb_pkt1[0].rob_idx), 64'd60);
        tick();
        check_eq("rot_g3", 64'(wb_pkt1[0].rob_idx), 64'd50);
        tick();
        check_eq("rot_g4", 64'(wb_pkt1[0].rob_idx), 64'd60);
        check_eq("rot_valid", 64'(wb_valid1), 64'h1);
        fu_valid1 = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
